// File: rtl/matrix_fmt_pkg.sv
// Shared types and constants for the matrix stream formatter: FSM states,
// ASCII codes, the packed event entry and a BCD digit-count helper.
package matrix_fmt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        POP,
        CHAR,
        CONV,
        PAD,
        SIGN,
        DIGITS,
        EROW,
        EEND
    } fmt_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_SEMI  = 8'h3B;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // One captured cycle of debug events: {byte_en, mat_en, erow, eend, byte, word}
    typedef struct packed {
        logic        byte_en;
        logic        mat_en;
        logic        erow;
        logic        eend;
        logic [7:0]  ch;
        logic [31:0] word;
    } fmt_entry_t;

    localparam int ENTRY_W = $bits(fmt_entry_t);

    function automatic logic [3:0] bcd_num_digits(input logic [39:0] bcd);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 0; i < 10; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) n = 4'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/matrix_stream_formatter_bcd.sv
// Sequential shift-add-3 binary to BCD converter: a start pulse loads the
// value, done pulses once 32 shifts later with the 10-digit result held.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin_in,
    output logic        done,
    output logic [39:0] bcd_out
);

    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [39:0] adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            bin_d  = bin_in;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[38:0], bin_q[31]};
            bin_d = {bin_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: rtl/matrix_stream_formatter.sv
// Renders PicoRV32 debug events as an ASCII byte stream with a ready/valid output.
// Define MATRIX_FMT_SIGNED_EN to format matrix words as two's complement.
module matrix_stream_formatter
    import matrix_fmt_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FIELD_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_byte_en,
    input  logic [7:0]  in_byte,
    input  logic        in_matrix_en,
    input  logic [31:0] in_matrix,
    input  logic        in_matrix_end_row,
    input  logic        in_matrix_end,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0] FIELD_W_C = 5'(FIELD_WIDTH);

    fmt_entry_t       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             any_event, push_ok, pop, fifo_full, fifo_empty;
    fmt_entry_t       in_entry, fifo_head;

    fmt_state_t       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    fmt_entry_t       entry_q, entry_d, sel;
    fmt_state_t       after_char, after_mat, after_erow, after_pad;
    logic             neg, bcd_start, bcd_done, load, emit_valid;
    logic [31:0]      word_sel, magnitude;
    logic [39:0]      bcd_val;
    logic [3:0]       ndig, digit;
    logic [4:0]       field_len, pad_cnt;
    logic [7:0]       emit_char, out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    assign in_entry   = {in_byte_en, in_matrix_en, in_matrix_end_row, in_matrix_end, in_byte, in_matrix};
    assign any_event  = in_byte_en | in_matrix_en | in_matrix_end_row | in_matrix_end;
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted then.
    assign push_ok    = any_event && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (any_event & ~push_ok);
        count_d    = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_sel = (state_q == POP) ? fifo_head.word : entry_q.word;
`ifdef MATRIX_FMT_SIGNED_EN
    assign neg       = entry_q.word[31];
    assign magnitude = word_sel[31] ? -word_sel : word_sel;
`else
    assign neg       = 1'b0;
    assign magnitude = word_sel;
`endif

    bin_to_bcd_seq u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (bcd_start),
        .bin_in  (magnitude),
        .done    (bcd_done),
        .bcd_out (bcd_val)
    );

    assign ndig      = bcd_num_digits(bcd_val);
    assign field_len = {1'b0, ndig} + {4'b0, neg};
    assign pad_cnt   = (FIELD_W_C > field_len) ? FIELD_W_C - field_len : 5'd0;
    assign load      = emit_valid && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        sel        = (state_q == POP) ? fifo_head : entry_q;
        after_erow = sel.eend ? EEND : IDLE;
        after_mat  = sel.erow ? EROW : after_erow;
        after_char = sel.mat_en ? CONV : after_mat;
        after_pad  = neg ? SIGN : DIGITS;
        state_d    = state_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        case (state_q)
            // Entries stay queued while the consumer stalls, so backpressure shows up as FIFO fill.
            IDLE:    if (!fifo_empty && out_ready) state_d = POP;
            POP: begin
                pop     = 1'b1;
                entry_d = fifo_head;
                state_d = fifo_head.byte_en ? CHAR : after_char;
            end
            CHAR:    if (load) state_d = after_char;
            CONV:    if (bcd_done) state_d = (pad_cnt != 5'd0) ? PAD : after_pad;
            PAD:     if (load && cnt_q == 5'd1) state_d = after_pad;
            SIGN:    if (load) state_d = DIGITS;
            DIGITS:  if (load && cnt_q == 5'd1) state_d = after_mat;
            EROW:    if (load && cnt_q == 5'd3) state_d = after_erow;
            EEND:    if (load && cnt_q == 5'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            case (state_d)
                PAD:     cnt_d = pad_cnt;
                DIGITS:  cnt_d = {1'b0, ndig};
                default: cnt_d = '0;
            endcase
        end else if (load) begin
            case (state_q)
                PAD, DIGITS: cnt_d = cnt_q - 5'd1;
                default:     cnt_d = cnt_q + 5'd1;
            endcase
        end
        bcd_start = (state_d == CONV) && (state_q != CONV);
    end

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (5'(i + 1) == cnt_q) digit = bcd_val[i*4 +: 4];
        end
        emit_valid = 1'b1;
        emit_char  = 8'h00;
        case (state_q)
            CHAR:   emit_char = entry_q.ch;
            PAD:    emit_char = ASCII_SPACE;
            SIGN:   emit_char = ASCII_MINUS;
            DIGITS: emit_char = ASCII_ZERO + {4'b0, digit};
            EROW: begin
                case (cnt_q[1:0])
                    2'd1:    emit_char = ASCII_SEMI;
                    2'd3:    emit_char = ASCII_LF;
                    default: emit_char = ASCII_SPACE;
                endcase
            end
            EEND:   emit_char = ASCII_LF;
            default: emit_valid = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_char;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule
